// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I widths and writeback types
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // Round-robin pointer and age bit encodings; the reset value 0 means "ALU".
  typedef enum logic { RR_ALU = 1'b0, RR_LD = 1'b1 } rr_t;
  typedef enum logic { AGE_ALU_OLDER = 1'b0, AGE_LD_OLDER = 1'b1 } age_t;

endpackage

// File: rtl/wb_slot.sv
// rtl/wb_slot.sv - one-entry writeback holding buffer with valid/ready handshake
module wb_slot
  import rv32i_pkg::*;
#(
  parameter int XLEN = rv32i_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  reg_idx_t        req_rd,
  input  logic [XLEN-1:0] req_data,
  input  logic            granted,
  output logic            full,
  output reg_idx_t        rd_q,
  output logic [XLEN-1:0] data_q,
  output logic            load
);

  assign req_ready = !full || granted;
  // x0 writes complete the handshake but never occupy the buffer.
  assign load      = req_valid && req_ready && (req_rd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else if (load) begin
      full   <= 1'b1;
      rd_q   <= req_rd;
      data_q <= req_data;
    end else if (granted) begin
      full   <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin ALU/load arbiter for the register file write port
module regfile_wb_arbiter
  import rv32i_pkg::*;
#(
  parameter int XLEN = rv32i_pkg::XLEN,
  parameter int NREG = rv32i_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  reg_idx_t        alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  reg_idx_t        ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            rf_write,
  output reg_idx_t        rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic [NREG-1:0] pending_mask
);

  logic            alu_full, ld_full;
  reg_idx_t        alu_rd_q, ld_rd_q;
  logic [XLEN-1:0] alu_data_q, ld_data_q;
  logic            alu_load, ld_load;
  logic            alu_grant, ld_grant;
  logic            both_full, same_rd;
  rr_t             rr;
  age_t            age;

  wb_slot #(.XLEN(XLEN)) u_alu_slot (
    .clk(clk), .rst(rst),
    .req_valid(alu_valid), .req_ready(alu_ready), .req_rd(alu_rd), .req_data(alu_data),
    .granted(alu_grant), .full(alu_full), .rd_q(alu_rd_q), .data_q(alu_data_q), .load(alu_load)
  );

  wb_slot #(.XLEN(XLEN)) u_ld_slot (
    .clk(clk), .rst(rst),
    .req_valid(ld_valid), .req_ready(ld_ready), .req_rd(ld_rd), .req_data(ld_data),
    .granted(ld_grant), .full(ld_full), .rd_q(ld_rd_q), .data_q(ld_data_q), .load(ld_load)
  );

  assign both_full = alu_full && ld_full;
  assign same_rd   = (alu_rd_q == ld_rd_q);

  // Same-register collisions go strictly by age so the later write wins in the file.
  always_comb begin
    alu_grant = 1'b0;
    ld_grant  = 1'b0;
    if (both_full) begin
      if (same_rd) begin
        ld_grant  = (age == AGE_LD_OLDER);
        alu_grant = (age == AGE_ALU_OLDER);
      end else begin
        ld_grant  = (rr == RR_LD);
        alu_grant = (rr == RR_ALU);
      end
    end else begin
      alu_grant = alu_full;
      ld_grant  = ld_full;
    end
  end

  assign rf_write = alu_grant || ld_grant;
  assign rf_rd    = alu_grant ? alu_rd_q   : (ld_grant ? ld_rd_q   : '0);
  assign rf_data  = alu_grant ? alu_data_q : (ld_grant ? ld_data_q : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr  <= RR_ALU;
      age <= AGE_ALU_OLDER;
    end else begin
      if (both_full && !same_rd)
        rr <= (rr == RR_ALU) ? RR_LD : RR_ALU;
      // A freshly loaded entry is always the newest; a tie makes the load older.
      if (alu_load)
        age <= AGE_LD_OLDER;
      else if (ld_load)
        age <= AGE_ALU_OLDER;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int r = 1; r < NREG; r++) begin
      pending_mask[r] = (alu_full && alu_rd_q == reg_idx_t'(r)) ||
                        (ld_full  && ld_rd_q  == reg_idx_t'(r));
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the RV32I `register_file`. It shares the file's single write port (`write`, `rd`, `reg_write`) between two writeback sources: the ALU result path and the load-data path. Each source gets a one-entry holding buffer with a valid/ready handshake, and the arbiter grants the port round-robin while keeping same-register writes in order. It also exports a pending-write scoreboard that decode uses for stall decisions.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `NREG`, 32, register count; `rd` width is `$clog2(NREG)`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU writeback request.
- `alu_ready`  out  1  ALU request accepted this edge when high with `alu_valid`.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `ld_valid`  in  1  load writeback request.
- `ld_ready`  out  1  load request accepted when high with `ld_valid`.
- `ld_rd`  in  5  load destination register.
- `ld_data`  in  XLEN  load data.
- `rf_write`  out  1  to `register_file.write`.
- `rf_rd`  out  5  to `register_file.rd`.
- `rf_data`  out  XLEN  to `register_file.reg_write`.
- `pending_mask`  out  NREG  bit r set while a write to register r is buffered.

## Operation
- Each source has a buffer: `full`, `rd`, `data`. A transfer happens when valid and ready are both high at a rising edge.
- `x_ready = !x_full || x_granted`, where `x_granted` is combinational within the current cycle.
- A request with rd = 0 is accepted (ready rules unchanged), discarded, and never written.
- Arbitration uses only the buffer contents:
  - One buffer full: grant it.
  - Both full, different rd: grant the source named by the round-robin pointer `rr`. The pointer flips to the other source after every contended grant and is unchanged otherwise.
  - Both full, same rd: grant the older entry, set by the `age` bit. `rr` is unchanged.
- `age` rules:
  - The entry accepted at the earlier edge is older.
  - On simultaneous acceptance at the same edge, the load entry is older.
- Outputs:
  - `rf_write = 1` while a grant exists.
  - `rf_rd` and `rf_data` come from the granted buffer; both are 0 when no grant.
  - The granted buffer empties at the next edge, or reloads from its source if a transfer happens at that same edge.
- `pending_mask[r] = (alu_full && alu_rd_q == r) || (ld_full && ld_rd_q == r)`. Bit 0 is always 0.
- `rr` and `age` are the only state beyond the two buffers. No internal write counter.

## Timing
- Reset (`rst` low, asynchronous) clears:
  - both `full` bits, all `rd` and `data` fields, `rr` (points to ALU) and `age`.
  - Resulting outputs: `rf_write = 0`, `rf_rd = 0`, `rf_data = 0`, `pending_mask = 0`, `alu_ready = 1`, `ld_ready = 1`.
- Reset mid-operation drops buffered writes. Nothing is written.
- Latency:
  - Request accepted at edge E0, uncontended: `rf_write` is high during cycle E0→E1, and `register_file` captures at E1.
  - Contended loser: write delayed one cycle per prior grant.
- Sustained throughput is one write per cycle. A source that is held off deasserts ready only while its buffer is full and not granted.
- A new request to register r is accepted only after the older write to r has been granted, or into the other source's empty buffer, with `age` ordering it.
- `pending_mask` updates combinationally from the buffers; it reflects the buffer state after each edge.

## Structure
- Shared package `rv32i_pkg`: `XLEN`, `NREG`, typedef `reg_idx_t` (logic [4:0]), typedef `wb_req_t` {`rd`, `data`}.
- One natural sub-module: `wb_slot`, the one-entry buffer with its `full` flag and ready logic, instantiated once per source.
- The arbiter, `rr`/`age` logic and scoreboard live in the top module.

## Test plan
- Reset: drive `rst` low mid-cycle with the ALU buffer full (rd = 5) → `rf_write = 0`, `pending_mask = 0`, both readies 1, asynchronously, before the next edge.
- Single ALU write: rd = 3, data = 0xDEADBEEF for one cycle → `rf_write = 1`, `rf_rd = 3`, `rf_data = 0xDEADBEEF` the next cycle; `pending_mask[3]` high for one cycle.
- x0 drop: load rd = 0, data = 0x1234 → `ld_ready = 1`, `rf_write` stays 0, `pending_mask = 0`.
- Contention, round-robin: both sources hold valid for 4 beats (ALU rd 1..4, load rd 11..14) → writes alternate 1, 11, 2, 12, 3, 13, 4, 14. The loser's ready is 0 while stalled.
- Same-rd ordering: load rd = 7 data = 0xA and ALU rd = 7 data = 0xB accepted at the same edge → 0xA written first, then 0xB; `pending_mask[7]` high for 2 cycles.
- Back-to-back throughput: ALU valid every cycle for 8 cycles with the load source idle → `alu_ready` stays 1 and 8 consecutive `rf_write` cycles occur.
